// File: rtl/rrb_pkg.sv
// Shared constants and helpers for the round-robin requester and its arbiter.
package rrb_pkg;

    localparam int CHANNELS = 8;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 4;
    localparam int CH_W     = $clog2(CHANNELS);

    // Index width wide enough for any channel count up to 64.
    localparam int IDX_W    = 6;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [2**IDX_W-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 2**IDX_W; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rrb_chan_fifo.sv
// Per-channel circular queue; pointers wrap naturally because depth is a power of 2.
module rrb_chan_fifo #(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(depth):0]   count
);

    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (aw+1)'(depth));

    // Storage is not reset; only the bookkeeping is.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rrb_requester.sv
// Per-channel queues feeding an external arbiter; pops one entry per cycle on a one-hot grant.
// Optional grant_err protocol checker enabled by defining RRB_GRANT_CHECK_EN.
module rrb_requester
    import rrb_pkg::*;
#(
    parameter int channels = CHANNELS,
    parameter int width    = WIDTH,
    parameter int depth    = DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_valid,
    input  logic [$clog2(channels)-1:0]  push_ch,
    input  logic [width-1:0]             push_data,
    output logic                         push_ready,
    output logic [channels-1:0]          request,
    input  logic [channels-1:0]          grant,
    output logic                         out_valid,
    output logic [$clog2(channels)-1:0]  out_ch,
    output logic [width-1:0]             out_data
`ifdef RRB_GRANT_CHECK_EN
    ,
    output logic                         grant_err
`endif
);

    localparam int ch_w  = $clog2(channels);
    localparam int cnt_w = $clog2(depth) + 1;

    logic [channels-1:0] push_fire;
    logic [channels-1:0] pop;
    logic [channels-1:0] empty;
    logic [channels-1:0] full;
    logic [channels-1:0] nonempty_next;
    logic [width-1:0]    dout [channels];
    logic [cnt_w-1:0]    cnt  [channels];
    logic                grant_onehot;
    logic [IDX_W-1:0]    grant_idx;
    logic [ch_w-1:0]     pop_idx;

    assign grant_onehot = (grant != '0) && ((grant & (grant - channels'(1))) == '0);
    assign grant_idx    = onehot_to_idx((2**IDX_W)'(grant));
    assign pop_idx      = grant_idx[ch_w-1:0];

    always_comb begin
        push_ready = 1'b0;
        for (int i = 0; i < channels; i++) begin
            if (push_ch == ch_w'(i)) push_ready = ~full[i];
        end
    end

    for (genvar i = 0; i < channels; i++) begin : g_chan
        assign push_fire[i] = push_valid && (push_ch == ch_w'(i)) && !full[i];
        assign pop[i]       = grant_onehot && grant[i] && !empty[i];
        // Occupancy after this cycle: a push keeps it non-empty, a pop of the last entry empties it.
        assign nonempty_next[i] = push_fire[i] ||
                                  (!empty[i] && !(pop[i] && (cnt[i] == cnt_w'(1))));

        rrb_chan_fifo #(
            .width (width),
            .depth (depth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_fire[i]),
            .pop   (pop[i]),
            .din   (push_data),
            .dout  (dout[i]),
            .empty (empty[i]),
            .full  (full[i]),
            .count (cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            request   <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            request   <= nonempty_next;
            out_valid <= |pop;
            if (|pop) begin
                out_ch   <= pop_idx;
                out_data <= dout[pop_idx];
            end
        end
    end

`ifdef RRB_GRANT_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_err <= 1'b0;
        end else if (((grant != '0) && !grant_onehot) || ((grant & ~request) != '0)) begin
            grant_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rrb_requester.sv
// Directed-vector bench for rrb_requester (8 channels, 32-bit data, depth 4).
module tb_rrb_requester;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic [2:0]  push_ch;
    logic [31:0] push_data;
    logic        push_ready;
    logic [7:0]  request;
    logic [7:0]  grant;
    logic        out_valid;
    logic [2:0]  out_ch;
    logic [31:0] out_data;
`ifdef RRB_GRANT_CHECK_EN
    logic        grant_err;
`endif

    int total = 0;
    int bad   = 0;

    rrb_requester dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ch    (push_ch),
        .push_data  (push_data),
        .push_ready (push_ready),
        .request    (request),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data)
`ifdef RRB_GRANT_CHECK_EN
        ,
        .grant_err  (grant_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [2:0] ch, input logic [31:0] data);
        push_valid = 1'b1;
        push_ch    = ch;
        push_data  = data;
        tick();
        push_valid = 1'b0;
    endtask

    // Hold a grant on ch until its request drops; entries must come out as first, first+1, ...
    task automatic drain(input logic [2:0] ch, input int exp_n, input logic [31:0] first);
        int n;
        n = 0;
        grant = 8'b1 << ch;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) begin
                chk("drain_data", out_data, first + 32'(n));
                chk("drain_ch", 64'(out_ch), 64'(ch));
                n++;
            end
            if (!request[ch]) break;
        end
        grant = '0;
        chk("drain_cnt", 64'(n), 64'(exp_n));
        chk("drain_req", 64'(request[ch]), 64'd0);
        tick();
        chk("drain_idle", 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        push_valid = 1'b0;
        push_ch    = '0;
        push_data  = '0;
        grant      = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_request", 64'(request), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_ch", 64'(out_ch), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
`ifdef RRB_GRANT_CHECK_EN
        chk("rst_grant_err", 64'(grant_err), 64'h0);
`endif

        // Weighted grant drains three entries in order from ch2.
        push1(3'd2, 32'hA1);
        chk("ch2_req_after_push", 64'(request), 64'h04);
        push1(3'd2, 32'hA2);
        push1(3'd2, 32'hA3);
        grant = 8'b0000_0100;
        tick();
        chk("ch2_v1", 64'(out_valid), 64'd1);
        chk("ch2_d1", 64'(out_data), 64'hA1);
        chk("ch2_c1", 64'(out_ch), 64'd2);
        chk("ch2_r1", 64'(request[2]), 64'd1);
        tick();
        chk("ch2_v2", 64'(out_valid), 64'd1);
        chk("ch2_d2", 64'(out_data), 64'hA2);
        chk("ch2_r2", 64'(request[2]), 64'd1);
        tick();
        chk("ch2_v3", 64'(out_valid), 64'd1);
        chk("ch2_d3", 64'(out_data), 64'hA3);
        chk("ch2_r3", 64'(request[2]), 64'd0);
        grant = '0;
        tick();
        chk("ch2_idle_v", 64'(out_valid), 64'd0);
        chk("ch2_hold_d", 64'(out_data), 64'hA3);
        chk("ch2_hold_c", 64'(out_ch), 64'd2);

        // Full queue: push_ready low regardless of push_valid; simultaneous push+pop only pops.
        for (int i = 0; i < 4; i++) push1(3'd0, 32'h10 + 32'(i));
        push_ch = 3'd0;
        #1;
        chk("ch0_full_ready", 64'(push_ready), 64'd0);
        push_ch = 3'd1;
        #1;
        chk("ch1_ready", 64'(push_ready), 64'd1);
        push_ch    = 3'd0;
        push_valid = 1'b1;
        push_data  = 32'hDEAD;
        grant      = 8'b0000_0001;
        #1;
        chk("ch0_full_ready_pv", 64'(push_ready), 64'd0);
        tick();
        push_valid = 1'b0;
        grant      = '0;
        chk("ch0_pop_v", 64'(out_valid), 64'd1);
        chk("ch0_pop_d", 64'(out_data), 64'h10);
        drain(3'd0, 3, 32'h11);

        // Push and pop together on a one-entry queue keeps occupancy at 1.
        push1(3'd5, 32'h55);
        push_valid = 1'b1;
        push_ch    = 3'd5;
        push_data  = 32'h56;
        grant      = 8'b0010_0000;
        #1;
        chk("ch5_ready", 64'(push_ready), 64'd1);
        tick();
        push_valid = 1'b0;
        grant      = '0;
        chk("ch5_v", 64'(out_valid), 64'd1);
        chk("ch5_d", 64'(out_data), 64'h55);
        chk("ch5_c", 64'(out_ch), 64'd5);
        chk("ch5_req", 64'(request[5]), 64'd1);
        drain(3'd5, 1, 32'h56);

        // Multi-hot grant pops nothing.
        push1(3'd1, 32'h41);
        push1(3'd4, 32'h44);
        grant = 8'b0001_0010;
        tick();
        chk("multi_v", 64'(out_valid), 64'd0);
        chk("multi_req", 64'(request), 64'h12);
`ifdef RRB_GRANT_CHECK_EN
        chk("multi_err", 64'(grant_err), 64'd1);
`endif
        grant = '0;
        tick();
`ifdef RRB_GRANT_CHECK_EN
        chk("multi_err_sticky", 64'(grant_err), 64'd1);
`endif
        drain(3'd1, 1, 32'h41);
        drain(3'd4, 1, 32'h44);

        // Grant to an empty channel is ignored.
        grant = 8'b1000_0000;
        tick();
        chk("empty_grant_v", 64'(out_valid), 64'd0);
        chk("empty_grant_req", 64'(request), 64'h0);
        grant = '0;

        // Reset mid-drain discards everything.
        for (int i = 0; i < 4; i++) push1(3'd3, 32'h30 + 32'(i));
        grant = 8'b0000_1000;
        tick();
        chk("ch3_d0", 64'(out_data), 64'h30);
        tick();
        chk("ch3_d1", 64'(out_data), 64'h31);
        grant = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_req", 64'(request), 64'h0);
        chk("mid_rst_v", 64'(out_valid), 64'd0);
        chk("mid_rst_d", 64'(out_data), 64'h0);
`ifdef RRB_GRANT_CHECK_EN
        chk("mid_rst_err", 64'(grant_err), 64'd0);
`endif
        grant = 8'b0000_1000;
        tick();
        chk("post_rst_grant_v", 64'(out_valid), 64'd0);
        grant = '0;
        push1(3'd3, 32'h99);
        drain(3'd3, 1, 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
